bias_loader: RTL and testbench

//  Write-side front end for the bias SRAM. Accepts a valid/ready stream of 32-bit bias words from the DMA.

---
 rtl/bias_loader_pkg.sv | 15 +
 rtl/bias_loader_if.sv | 25 ++
 rtl/bias_loader_addr_gen.sv | 48 ++++
 rtl/bias_loader.sv | 125 ++++++++++++
 tb/tb_bias_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bias_loader_pkg.sv
// Shared types and constants for the bias SRAM write-side loader.
package bias_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        FLUSH,
        DONE
    } bias_ld_state_t;

    localparam int BIAS_LANES  = 8;
    localparam int BIAS_WORD_W = 32;

endpackage

// File: rtl/bias_loader_if.sv
// Stream-in / SRAM-write-out bundle of the bias loader.
// master: the loader (consumes the stream, drives the SRAM write port).
// slave : the DMA/SRAM side.
interface bias_loader_if
    import bias_pkg::*;
#(
    parameter int ADDR_BIT = 7
);
    logic                   s_valid;
    logic [BIAS_WORD_W-1:0] s_data;
    logic                   s_ready;
    logic                   sram_WE;
    logic [ADDR_BIT-1:0]    sram_ADDR;
    logic [BIAS_WORD_W-1:0] sram_DI;

    modport master (
        input  s_valid, s_data,
        output s_ready, sram_WE, sram_ADDR, sram_DI
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, sram_WE, sram_ADDR, sram_DI
    );
endinterface

// File: rtl/bias_loader_addr_gen.sv
// Address generator for the bias loader: latched base/word count, running
// index, modulo-2**ADDR_BIT write address and tail flags.
// last_word    : the current index is the final stream word (idx == num-1).
// lane_aligned : the index after the current write is a multiple of LANES.
module bias_addr_gen
    import bias_pkg::*;
#(
    parameter int ADDR_BIT = 7,
    parameter int LANES    = BIAS_LANES
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                load,
    input  logic [ADDR_BIT-1:0] base_in,
    input  logic [ADDR_BIT:0]   num_in,
    input  logic                step,
    output logic [ADDR_BIT-1:0] addr,
    output logic                last_word,
    output logic                lane_aligned
);
    localparam logic [ADDR_BIT:0] LANE_MASK = (ADDR_BIT+1)'(LANES - 1);

    logic [ADDR_BIT-1:0] base_q;
    logic [ADDR_BIT:0]   num_q;
    logic [ADDR_BIT:0]   idx_q;
    logic [ADDR_BIT:0]   idx_inc;

    // Latch base/count on an accepted start; advance the index per write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            base_q <= '0;
            num_q  <= '0;
            idx_q  <= '0;
        end else if (load) begin
            base_q <= base_in;
            num_q  <= num_in;
            idx_q  <= '0;
        end else if (step) begin
            idx_q  <= idx_inc;
        end
    end

    assign idx_inc      = idx_q + 1'b1;
    assign addr         = base_q + idx_q[ADDR_BIT-1:0];
    assign last_word    = (idx_inc == num_q);
    assign lane_aligned = ((idx_inc & LANE_MASK) == '0);

endmodule

// File: rtl/bias_loader.sv
// Bias SRAM write-side front end: accepts a valid/ready stream of bias words
// and writes them one per cycle to consecutive SRAM addresses from a base.
// Optional macro BIAS_LOADER_PAD_EN: zero-fill the tail up to a LANES boundary.
module bias_loader
    import bias_pkg::*;
#(
    parameter int ADDR_BIT = 7,
    parameter int LANES    = BIAS_LANES
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [ADDR_BIT-1:0] base_addr,
    input  logic [ADDR_BIT:0]   num_words,
    bias_loader_if.master       bus,
    output logic                busy,
    output logic                done
);
    bias_ld_state_t      state_q, state_d;
    logic                rdy;
    logic                wr;
    logic                wr_pad;
    logic                step;
    logic                load;
    logic [ADDR_BIT-1:0] addr;
    logic                last_word;
    logic                lane_aligned;

    bias_addr_gen #(
        .ADDR_BIT(ADDR_BIT),
        .LANES   (LANES)
    ) u_addr_gen (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .load        (load),
        .base_in     (base_addr),
        .num_in      (num_words),
        .step        (step),
        .addr        (addr),
        .last_word   (last_word),
        .lane_aligned(lane_aligned)
    );

`ifndef BIAS_LOADER_PAD_EN
    logic unused_lane_aligned;
    assign unused_lane_aligned = lane_aligned;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-state controls.
    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        wr      = 1'b0;
        wr_pad  = 1'b0;
        step    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = (num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                rdy  = 1'b1;
                if (bus.s_valid) begin
                    wr   = 1'b1;
                    step = 1'b1;
                    if (last_word) begin
`ifdef BIAS_LOADER_PAD_EN
                        state_d = lane_aligned ? FLUSH : PAD;
`else
                        state_d = FLUSH;
`endif
                    end
                end
            end
`ifdef BIAS_LOADER_PAD_EN
            PAD: begin
                busy   = 1'b1;
                wr     = 1'b1;
                wr_pad = 1'b1;
                step   = 1'b1;
                if (lane_aligned) state_d = FLUSH;
            end
`endif
            FLUSH: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready = rdy;

    // Registered SRAM write port; address/data hold when no write is issued.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.sram_WE   <= 1'b0;
            bus.sram_ADDR <= '0;
            bus.sram_DI   <= '0;
        end else begin
            bus.sram_WE <= wr;
            if (wr) begin
                bus.sram_ADDR <= addr;
                bus.sram_DI   <= wr_pad ? '0 : bus.s_data;
            end
        end
    end

endmodule

// File: tb/tb_bias_loader.sv
// Directed scoreboard bench for bias_loader (ADDR_BIT=7, LANES=8).
// Honours BIAS_LOADER_PAD_EN when the design is built with it.
module tb_bias_loader;
    import bias_pkg::*;

    localparam int AW = 7;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy;
    logic          done;

    bias_loader_if #(.ADDR_BIT(AW)) bus ();

    bias_loader #(
        .ADDR_BIT(AW),
        .LANES   (8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .base_addr(base_addr),
        .num_words(num_words),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  writes   = 0;
    int  w0       = 0;
    int  we_run   = 0;
    int  max_run  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every SRAM write must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (bus.sram_WE === 1'b1) begin
            wr_t e;
            writes++;
            we_run++;
            if (we_run > max_run) max_run = we_run;
            check("wr_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 64'(bus.sram_ADDR), 64'(e.addr));
                check("wr_data", 64'(bus.sram_DI), 64'(e.data));
            end
        end else begin
            we_run = 0;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
        w0        = writes;
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] b, input int i, input logic [31:0] d);
        int k = 0;
        logic [AW-1:0] a;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        @(negedge CLK);
        while (bus.s_ready !== 1'b1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("s_ready", 64'(bus.s_ready), 64'd1);
        if (bus.s_ready === 1'b1) begin
            @(posedge CLK);
            a = b + AW'(i);
            sb.push_back({a, d});
            #1;
        end
    endtask

    task automatic finish_load(input logic [AW-1:0] b, input int n);
        int k    = 0;
        int npad = 0;
        bus.s_valid = 1'b0;
`ifdef BIAS_LOADER_PAD_EN
        for (int idx = n; (idx % 8) != 0; idx++) begin
            logic [AW-1:0] a;
            a = b + AW'(idx);
            sb.push_back({a, 32'h0});
            npad++;
        end
`endif
        do begin
            @(negedge CLK);
            k++;
        end while (done !== 1'b1 && k < 40);
        check("done_latency", 64'(k), 64'(2 + npad));
        check("busy_at_done", 64'(busy), 64'd0);
        @(negedge CLK);
        check("done_one_cycle", 64'(done), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("write_count", 64'(writes - w0), 64'(n + npad));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset values
        #3;
        check("rst_we", 64'(bus.sram_WE), 64'd0);
        check("rst_addr", 64'(bus.sram_ADDR), 64'd0);
        check("rst_di", 64'(bus.sram_DI), 64'd0);
        check("rst_ready", 64'(bus.s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // T1: base 0, 8 back-to-back words
        max_run = 0;
        do_start(7'd0, 8'd8);
        for (int i = 0; i < 8; i++) send(7'd0, i, 32'h100 + 32'(i));
        finish_load(7'd0, 8);
        check("t1_consecutive_we", 64'(max_run), 64'd8);

        // T2: base 4, 5 words with valid toggling
        do_start(7'd4, 8'd5);
        for (int i = 0; i < 5; i++) begin
            send(7'd4, i, 32'hA200 + 32'(i * 3));
            if (i != 4) begin
                bus.s_valid = 1'b0;
                @(posedge CLK);
                #1;
            end
        end
        finish_load(7'd4, 5);

        // T3: wrap at top of address space; start mid-load is ignored
        do_start(7'd126, 8'd4);
        send(7'd126, 0, 32'hDEAD_0000);
        send(7'd126, 1, 32'hDEAD_0001);
        base_addr = 7'd50;
        num_words = 8'd1;
        start     = 1'b1;
        send(7'd126, 2, 32'hDEAD_0002);
        start     = 1'b0;
        send(7'd126, 3, 32'hDEAD_0003);
        finish_load(7'd126, 4);

        // T4: zero-length load
        w0 = writes;
        do_start(7'd5, 8'd0);
        @(negedge CLK);
        check("t4_done", 64'(done), 64'd1);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_ready", 64'(bus.s_ready), 64'd0);
        @(negedge CLK);
        check("t4_done_end", 64'(done), 64'd0);
        check("t4_no_write", 64'(writes - w0), 64'd0);
        @(posedge CLK);
        #1;

        // T5: reset after 3 of 8 words, then a fresh load
        do_start(7'd10, 8'd8);
        for (int i = 0; i < 3; i++) send(7'd10, i, 32'h5000 + 32'(i));
        bus.s_valid = 1'b0;
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1;
        check("t5_rst_we", 64'(bus.sram_WE), 64'd0);
        check("t5_rst_addr", 64'(bus.sram_ADDR), 64'd0);
        check("t5_rst_di", 64'(bus.sram_DI), 64'd0);
        check("t5_rst_ready", 64'(bus.s_ready), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_sb_drained", 64'(sb.size()), 64'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(negedge CLK);
        check("t5_idle_ready", 64'(bus.s_ready), 64'd0);
        check("t5_idle_busy", 64'(busy), 64'd0);
        @(posedge CLK);
        #1;
        do_start(7'd20, 8'd8);
        for (int i = 0; i < 8; i++) send(7'd20, i, 32'h5100 + 32'(i));
        finish_load(7'd20, 8);

        // T6: 10 words from base 0 (zero tail to 15 when padding is built in)
        do_start(7'd0, 8'd10);
        for (int i = 0; i < 10; i++) send(7'd0, i, 32'h600 + 32'(i));
        finish_load(7'd0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
